// File: rtl/sram_like_responder.sv
// Memory-side responder for the SRAM-like request/response interface.
// Accepted requests wait in an in-order queue for at least RESP_LAT cycles,
// then pop one per cycle; writes are applied to the private memory at pop.
module sram_like_responder #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MEM_AW   = 10,
  parameter int unsigned RESP_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_req,
  input  logic        sram_wr,
  input  logic [1:0]  sram_size,
  input  logic [31:0] sram_addr,
  input  logic [3:0]  sram_wstrb,
  input  logic [31:0] sram_wdata,
  output logic        sram_addr_ok,
  output logic [31:0] sram_rdata,
  output logic        sram_data_ok,
  input  logic        accept_block,
  input  logic        resp_hold
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(RESP_LAT + 1);

  // Queue entry storage; contents are only meaningful for valid slots.
  logic              wr_q    [DEPTH];
  logic [1:0]        size_q  [DEPTH];
  logic [MEM_AW-1:0] addr_q  [DEPTH];
  logic [3:0]        wstrb_q [DEPTH];
  logic [31:0]       wdata_q [DEPTH];
  logic [CW-1:0]     cnt_q   [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;

  logic [31:0] mem [2**MEM_AW];

  logic full;
  logic push;
  logic pop;
  logic [MEM_AW-1:0] head_addr;
  logic [1:0]        head_size;
  logic              unused_bits;

  assign full         = (count_q == (PW + 1)'(DEPTH));
  assign sram_addr_ok = ~reset & ~full & ~accept_block;
  assign push         = sram_req & sram_addr_ok;
  assign pop          = (count_q != '0) && (cnt_q[head_q] == '0) && !resp_hold;
  assign head_addr    = addr_q[head_q];
  assign head_size    = size_q[head_q];

  // Size is kept with the entry but never affects data; high/low address bits alias.
  assign unused_bits = ^{head_size, sram_addr[31:MEM_AW+2], sram_addr[1:0]};

  // Queue pointers, occupancy and the registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      sram_data_ok <= 1'b0;
      sram_rdata   <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      sram_data_ok <= pop;
      if (pop) sram_rdata <= wr_q[head_q] ? 32'h0 : mem[head_addr];
    end
  end

  // Entry capture at the tail and per-entry latency countdown (saturating at 0).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && tail_q == PW'(i)) begin
        wr_q[i]    <= sram_wr;
        size_q[i]  <= sram_size;
        addr_q[i]  <= sram_addr[MEM_AW+1:2];
        wstrb_q[i] <= sram_wstrb;
        wdata_q[i] <= sram_wdata;
        cnt_q[i]   <= CW'(RESP_LAT - 1);
      end else if (cnt_q[i] != '0) begin
        cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // Byte-masked memory write when a write entry pops; array is never reset.
  always_ff @(posedge clk) begin
    if (pop && wr_q[head_q]) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[head_q][b]) mem[head_addr][8*b +: 8] <= wdata_q[head_q][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed scenarios plus random traffic, all
// checked against a timestamped transaction model of the queue and memory.
module tb_sram_like_responder;

  localparam int DEPTH    = 4;
  localparam int MEM_AW   = 10;
  localparam int RESP_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic        accept_block, resp_hold;

  always #5 clk = ~clk;

  sram_like_responder #(
    .DEPTH   (DEPTH),
    .MEM_AW  (MEM_AW),
    .RESP_LAT(RESP_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sram_req    (req),
    .sram_wr     (wr),
    .sram_size   (size),
    .sram_addr   (addr),
    .sram_wstrb  (wstrb),
    .sram_wdata  (wdata),
    .sram_addr_ok(addr_ok),
    .sram_rdata  (rdata),
    .sram_data_ok(data_ok),
    .accept_block(accept_block),
    .resp_hold   (resp_hold)
  );

  // Model: each accepted request remembers the edge from which it may respond.
  typedef struct {
    logic        wr;
    int          idx;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          ready;
  } txn_t;

  txn_t        q[$];
  logic [31:0] mem_m[int];
  int          edge_n = 0;
  int          total = 0;
  int          bad = 0;
  int          n_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic drive(input logic r, input logic w, input int idx, input logic [3:0] s,
                       input logic [31:0] d);
    logic [31:0] a;
    a = $urandom;
    a[MEM_AW+1:2] = idx[MEM_AW-1:0];
    req   = r;
    wr    = w;
    size  = 2'($urandom_range(0, 3));
    addr  = a;
    wstrb = s;
    wdata = d;
  endtask

  // One clock cycle: called at posedge+1 with inputs already driven.
  task automatic step();
    logic        exp_ok, acc, pop;
    logic [31:0] exp_rd, word;
    txn_t        t, h;
    #3;
    exp_ok = !accept_block && (q.size() < DEPTH);
    check("addr_ok", {31'b0, addr_ok}, {31'b0, exp_ok});
    acc = req && exp_ok;
    if (req && addr_ok) n_acc++;
    pop = (q.size() > 0) && (q[0].ready <= edge_n + 1) && !resp_hold;
    t.wr = wr; t.idx = int'(addr[MEM_AW+1:2]); t.wstrb = wstrb; t.wdata = wdata;
    @(posedge clk);
    edge_n++;
    #1;
    exp_rd = '0;
    if (pop) begin
      h = q.pop_front();
      if (h.wr) begin
        word = mem_m.exists(h.idx) ? mem_m[h.idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (h.wstrb[b]) word[8*b +: 8] = h.wdata[8*b +: 8];
        mem_m[h.idx] = word;
      end else begin
        exp_rd = mem_m[h.idx];
      end
    end
    if (acc) begin
      t.ready = edge_n + RESP_LAT;
      q.push_back(t);
    end
    check("data_ok", {31'b0, data_ok}, {31'b0, pop});
    if (pop) check("rdata", rdata, exp_rd);
  endtask

  task automatic drain();
    req = 1'b0; resp_hold = 1'b0; accept_block = 1'b0;
    for (int i = 0; i < 50 && q.size() > 0; i++) step();
    step();
  endtask

  initial begin
    reset = 1'b1; accept_block = 1'b0; resp_hold = 1'b0;
    drive(1'b0, 1'b0, 0, 4'h0, 32'h0);
    #2;
    check("rst_addr_ok", {31'b0, addr_ok}, 32'h0);
    check("rst_data_ok", {31'b0, data_ok}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Initialise words 0..15 with their index.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, i, 4'hf, 32'(i));
      step();
    end
    drain();

    // Ten sequential reads across several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, i, 4'h0, 32'h0);
      step();
    end
    drain();

    // Single read latency, then partial write followed by read of same word.
    drive(1'b1, 1'b1, 4, 4'hf, 32'h11223344); step();
    drive(1'b1, 1'b1, 1, 4'hf, 32'hAABBCCDD); step();
    drain();
    drive(1'b1, 1'b0, 4, 4'h0, 32'h0); step();
    req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    drive(1'b1, 1'b1, 1, 4'b0101, 32'h00110022); step();
    drive(1'b1, 1'b0, 1, 4'h0, 32'h0); step();
    drain();
    check("merged_word", mem_m[1], 32'hAA11CC22);

    // Fill the queue under resp_hold, then release while still requesting.
    n_acc = 0;
    resp_hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, i, 4'h0, 32'h0);
      step();
    end
    check("fill_accepts", n_acc, 4);
    resp_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, i + 3, 4'h0, 32'h0);
      step();
    end
    drain();

    // accept_block with requests pending and responses in flight.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, i + 7, 4'h0, 32'h0);
      step();
    end
    n_acc = 0;
    accept_block = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("block_accepts", n_acc, 0);
    accept_block = 1'b0;
    drain();

    // Three entries queued, resp_hold toggling every cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, i + 10, 4'h0, 32'h0);
      step();
    end
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      resp_hold = i[0] ? 1'b0 : 1'b1;
      step();
    end
    drain();

    // Reset mid-flight: 2 reads and a write to word 5 remain queued.
    resp_hold = 1'b1;
    drive(1'b1, 1'b0, 4, 4'h0, 32'h0);        step();
    drive(1'b1, 1'b0, 1, 4'h0, 32'h0);        step();
    drive(1'b1, 1'b0, 2, 4'h0, 32'h0);        step();
    drive(1'b1, 1'b1, 5, 4'hf, 32'hDEADBEEF); step();
    req = 1'b0; resp_hold = 1'b0;
    step();
    #3;
    reset = 1'b1;
    #1;
    check("midrst_data_ok", {31'b0, data_ok}, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_addr_ok", {31'b0, addr_ok}, 32'h0);
    q.delete();
    @(posedge clk); #1;
    edge_n++;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    drive(1'b1, 1'b0, 5, 4'h0, 32'h0); step();
    drain();
    check("word5_kept", mem_m[5], 32'h5);

    // Random traffic over words 0..15 with random stalls.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15),
            4'($urandom), $urandom);
      accept_block = ($urandom_range(0, 9) == 0);
      resp_hold    = ($urandom_range(0, 3) == 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

Memory-side responder for the CPU's SRAM-like request/response interface, which carries req/wr/size/addr/wstrb/wdata in one direction and addr_ok/data_ok/rdata in the other. It accepts address-phase requests into an in-order outstanding queue and returns one data_ok pulse per accepted request after a programmable latency. It backs a private word memory. It sits on either the inst or the data port of the CPU top in simulation and SoC-lite builds. Two stall inputs let the bench exercise the CPU's request-waiting and exception-discard paths.

## Interface
- DEPTH, 4 — outstanding request queue entries; power of two, at least 2.
- MEM_AW, 10 — word-address bits; memory holds 2^MEM_AW 32-bit words.
- RESP_LAT, 2 — minimum cycles an entry waits in the queue before it can respond; at least 1.

- clk  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-high; clears all control state.
- sram_req  in  1  — request valid.
- sram_wr  in  1  — 1 = write, 0 = read.
- sram_size  in  2  — accepted and stored; ignored for data (wstrb defines the written bytes).
- sram_addr  in  32  — byte address; word index = sram_addr[MEM_AW+1:2]; other bits ignored (aliasing).
- sram_wstrb  in  4  — byte enables for writes.
- sram_wdata  in  32  — write data.
- sram_addr_ok  out  1  — request accepted this cycle when high together with sram_req.
- sram_rdata  out  32  — read data, valid while sram_data_ok is high.
- sram_data_ok  out  1  — one-cycle response pulse, one per accepted request, in acceptance order.
- accept_block  in  1  — bench stall: forces sram_addr_ok low.
- resp_hold  in  1  — bench stall: blocks responses; queue countdowns continue.

## Operation
- sram_addr_ok is combinational: ~reset & ~full & ~accept_block. It does not depend on sram_req.
- Accept: sram_req & sram_addr_ok at a rising edge. The edge pushes {wr, size, word addr, wstrb, wdata, cnt = RESP_LAT-1} at the tail.
- Countdown: every valid entry decrements cnt by 1 each cycle, saturating at 0.
- Pop: at a rising edge where the head is valid, head cnt == 0 and ~resp_hold, the head is removed.
  - If the head is a read: sram_rdata <= mem[addr].
  - If the head is a write: each byte i with wstrb[i]=1 is written, mem[addr][8i+7:8i] <= wdata[8i+7:8i]; sram_rdata <= 0.
  - sram_data_ok <= 1 at that edge; it is 0 after every edge with no pop.
- Writes take effect at pop, not at accept. A read behind a write to the same word returns the merged value.
- Queue control: head/tail pointers of log2(DEPTH) bits that wrap at DEPTH, plus a count of log2(DEPTH)+1 bits. full = (count == DEPTH); empty = (count == 0).
- Push and pop on the same edge: count unchanged, both pointers advance. This is legal when full, because addr_ok was already 0, so no push occurs.
- Memory array is not reset. Its contents are X until written or preloaded by the bench through $readmemh on a hierarchical path.

## Timing
- Reset values: sram_data_ok = 0, sram_rdata = 0, count = 0, pointers = 0, sram_addr_ok = 0 while reset is high.
- Reset asserted mid-operation: all queued entries are dropped immediately. No data_ok is produced for them, and unpopped writes are never applied.
- Latency on an empty, unstalled queue: a request accepted at the end of cycle t gets sram_data_ok high in cycle t+RESP_LAT+1 (for RESP_LAT=2, cycle t+3).
- Throughput: at most one accept and one response per cycle. After the first response, back-to-back accepts produce back-to-back data_ok pulses.
- Ordering: strictly FIFO, so responses come back in acceptance order.
- resp_hold: a held head with cnt already 0 pops on the first edge after resp_hold falls.
- accept_block: does not affect responses in flight.
- Full boundary: with DEPTH entries outstanding, sram_addr_ok is 0 in every cycle until the edge after the next pop.

## Test plan
- Single read, RESP_LAT=2, mem[4]=0x11223344:
  - Stimulus: req=1, wr=0, addr=0x10, accepted end of cycle 0.
  - Required: data_ok=1 only in cycle 3; rdata=0x11223344 in cycle 3.
- Partial write then read to the same word, back-to-back, mem[1]=0xAABBCCDD:
  - Stimulus: write addr=0x4, wstrb=0b0101, wdata=0x00110022; then read addr=0x4.
  - Required: two consecutive data_ok pulses; first has rdata=0, second has rdata=0xAA11CC22.
- Fill queue, DEPTH=4:
  - Stimulus: req held high with resp_hold=1.
  - Required: exactly 4 accepts, then addr_ok=0. After resp_hold drops, 4 consecutive data_ok pulses in order; addr_ok returns to 1 the cycle after the first pop.
- Stall inputs:
  - Stimulus: accept_block=1 for 5 cycles with req=1.
  - Required: no accept, and no change to in-flight responses.
  - Stimulus: toggle resp_hold 1/0 every cycle with 3 entries queued.
  - Required: data_ok only in cycles with no hold at the prior edge.
- Async reset mid-flight:
  - Stimulus: 2 reads and 1 write queued; reset asserted between clock edges.
  - Required: data_ok=0 and rdata=0 immediately; no data_ok after release; the written word keeps its old value.
- Pointer wrap, DEPTH=4:
  - Stimulus: 10 sequential reads of addrs 0x0..0x24 with preloaded values = index.
  - Required: rdata sequence 0..9, with no drop or duplicate across pointer wrap.
